// File: rtl/ex_muldiv_pkg.sv
// Shared encodings for the EX-stage M-extension unit: funct3 ops, FSM states, latched op metadata.
// Latency: none (types, constants and pure helper functions only).
// Backpressure: not applicable.
package ex_muldiv_pkg;

  localparam int XLEN_DEFAULT       = 32;
  localparam int REG_ADDR_W_DEFAULT = 5;

  // funct3 encodings of the M-extension ops
  typedef enum logic [2:0] {
    MD_OP_MUL    = 3'b000,
    MD_OP_MULH   = 3'b001,
    MD_OP_MULHSU = 3'b010,
    MD_OP_MULHU  = 3'b011,
    MD_OP_DIV    = 3'b100,
    MD_OP_DIVU   = 3'b101,
    MD_OP_REM    = 3'b110,
    MD_OP_REMU   = 3'b111
  } md_op_t;

  typedef enum logic [1:0] {
    EXMD_IDLE = 2'd0,
    EXMD_ONE  = 2'd1,
    EXMD_DIV  = 2'd2,
    EXMD_DONE = 2'd3
  } exmd_state_t;

  // Op state captured at accept; the sign fix-ups are decided up front from the raw operands
  typedef struct packed {
    md_op_t op;
    logic   neg_q;
    logic   neg_r;
  } md_meta_t;

  // DIV and REM treat their operands as signed; DIVU/REMU and all multiplies do not
  function automatic logic md_div_signed(input logic [2:0] op);
    return op[2] & ~op[0];
  endfunction

  function automatic logic md_is_div(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/div_restoring.sv
// Unsigned restoring divider: one quotient bit per cycle on magnitudes prepared by the caller.
// Latency: XLEN cycles after start; done is high in the last one, quotient/remainder valid beside it.
// Backpressure: none; start is only legal when idle, abort drops the division at the next edge.
module div_restoring
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

  logic             run;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  rem_q;
  logic [XLEN-1:0]  quo_q;
  logic [XLEN-1:0]  dvs_q;

  logic [XLEN:0]    shifted;
  logic [XLEN:0]    diff;
  logic             ge;
  logic [XLEN-1:0]  rem_nxt;
  logic [XLEN-1:0]  quo_nxt;

  // One restoring step: shift in the next dividend bit, subtract if it fits, record the quotient bit
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, dvs_q};
    ge      = ~diff[XLEN];
    rem_nxt = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quo_nxt = {quo_q[XLEN-2:0], ge};
  end

  // The final step's result is handed out combinationally so the caller can register it on the same edge
  assign done      = run && (cnt == LAST_ITER);
  assign quotient  = quo_nxt;
  assign remainder = rem_nxt;

  // Iteration state: load on start, step while running, stop after the last step or on abort
  always_ff @(posedge clk) begin
    if (rst) begin
      run   <= 1'b0;
      cnt   <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (abort) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      run   <= 1'b1;
      cnt   <= '0;
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
    end else if (run) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
      cnt   <= cnt + CNT_W'(1);
      if (done) begin
        run <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// RV32M/RV64M execute unit: MUL/MULH*/DIV*/REM* beside the ALU, stalling the front end via busy.
// Latency: multiplies and special-case divides 2 cycles; other divides XLEN+1 cycles to out_valid.
// Backpressure: in_ready only in IDLE/DONE; no output backpressure; flush drops in-flight and presented ops.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_op,
  input  logic [XLEN-1:0]       in_a,
  input  logic [XLEN-1:0]       in_b,
  input  logic [REG_ADDR_W-1:0] in_rd,
  output logic                  out_valid,
  output logic [XLEN-1:0]       out_data,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  busy
);

  localparam logic [XLEN-1:0] SIGNED_MIN = {1'b1, {(XLEN-1){1'b0}}};

  exmd_state_t           state;
  exmd_state_t           state_nxt;
  logic                  idle_or_done;
  logic                  accept;

  logic                  in_a_neg;
  logic                  in_b_neg;
  logic                  in_special;
  logic                  in_long_div;
  logic [XLEN-1:0]       mag_a;
  logic [XLEN-1:0]       mag_b;

  logic [XLEN-1:0]       a_q;
  logic [XLEN-1:0]       b_q;
  logic [REG_ADDR_W-1:0] rd_q;
  md_meta_t              meta_q;

  logic                  div_done;
  logic [XLEN-1:0]       div_quo;
  logic [XLEN-1:0]       div_rem;

  logic                  sign_a;
  logic                  sign_b;
  logic [XLEN:0]         mul_a;
  logic [XLEN:0]         mul_b;
  logic [2*XLEN-1:0]     ext_a;
  logic [2*XLEN-1:0]     ext_b;
  logic [2*XLEN-1:0]     prod;
  logic [XLEN-1:0]       one_result;
  logic [XLEN-1:0]       div_result;

  assign accept = in_valid && in_ready && !flush;

  // Classify the presented op: divide-by-zero and signed overflow finish in ONE without the divider
  always_comb begin
    in_a_neg    = md_div_signed(in_op) & in_a[XLEN-1];
    in_b_neg    = md_div_signed(in_op) & in_b[XLEN-1];
    in_special  = md_is_div(in_op) &&
                  ((in_b == '0) ||
                   (md_div_signed(in_op) && (in_a == SIGNED_MIN) && (in_b == '1)));
    in_long_div = md_is_div(in_op) && !in_special;
    mag_a       = in_a_neg ? -in_a : in_a;
    mag_b       = in_b_neg ? -in_b : in_b;
  end

  // Capture the accepted op; the divider keeps its own copy of the magnitudes
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      rd_q   <= '0;
      meta_q <= '{op: MD_OP_MUL, neg_q: 1'b0, neg_r: 1'b0};
    end else if (accept) begin
      a_q    <= in_a;
      b_q    <= in_b;
      rd_q   <= in_rd;
      meta_q <= '{op: md_op_t'(in_op), neg_q: in_a_neg ^ in_b_neg, neg_r: in_a_neg};
    end
  end

  div_restoring #(
    .XLEN(XLEN)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (accept && in_long_div),
    .abort    (flush),
    .dividend (mag_a),
    .divisor  (mag_b),
    .done     (div_done),
    .quotient (div_quo),
    .remainder(div_rem)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EXMD_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: flush overrides everything except reset
  always_comb begin
    state_nxt = state;
    case (state)
      EXMD_IDLE, EXMD_DONE: begin
        if (accept) begin
          state_nxt = in_long_div ? EXMD_DIV : EXMD_ONE;
        end else begin
          state_nxt = EXMD_IDLE;
        end
      end
      EXMD_ONE: state_nxt = EXMD_DONE;
      EXMD_DIV: begin
        if (div_done) begin
          state_nxt = EXMD_DONE;
        end
      end
      default: state_nxt = EXMD_IDLE;
    endcase
    if (flush) begin
      state_nxt = EXMD_IDLE;
    end
  end

  // Handshake outputs: busy is combinational so a presented op stalls the front end immediately
  always_comb begin
    idle_or_done = (state == EXMD_IDLE) || (state == EXMD_DONE);
    in_ready     = idle_or_done;
    out_valid    = (state == EXMD_DONE);
    busy         = !idle_or_done || (in_valid && !flush);
  end

  // Multiplier: operands widened to XLEN+1 with per-op sign bit, product kept modulo 2^(2*XLEN)
  always_comb begin
    sign_a = (meta_q.op == MD_OP_MULH) || (meta_q.op == MD_OP_MULHSU);
    sign_b = (meta_q.op == MD_OP_MULH);
    mul_a  = {sign_a & a_q[XLEN-1], a_q};
    mul_b  = {sign_b & b_q[XLEN-1], b_q};
    ext_a  = {{(XLEN-1){mul_a[XLEN]}}, mul_a};
    ext_b  = {{(XLEN-1){mul_b[XLEN]}}, mul_b};
    prod   = ext_a * ext_b;
  end

  // Result produced in ONE: multiplies, or a divide that hit divide-by-zero / signed overflow
  always_comb begin
    one_result = '0;
    case (meta_q.op)
      MD_OP_MUL:                            one_result = prod[XLEN-1:0];
      MD_OP_MULH, MD_OP_MULHSU, MD_OP_MULHU: one_result = prod[2*XLEN-1:XLEN];
      MD_OP_DIV, MD_OP_DIVU:                one_result = (b_q == '0) ? '1 : a_q;
      MD_OP_REM, MD_OP_REMU:                one_result = (b_q == '0) ? a_q : '0;
      default:                              one_result = '0;
    endcase
  end

  // Divider result with sign restored: quotient negative on differing signs, remainder follows dividend
  always_comb begin
    if (meta_q.op[1]) begin
      div_result = meta_q.neg_r ? -div_rem : div_rem;
    end else begin
      div_result = meta_q.neg_q ? -div_quo : div_quo;
    end
  end

  // Result registers load on entry to DONE only, so a flushed op leaves the last result in place
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
      out_rd   <= '0;
    end else if (!flush && (state == EXMD_ONE)) begin
      out_data <= one_result;
      out_rd   <= rd_q;
    end else if (!flush && (state == EXMD_DIV) && div_done) begin
      out_data <= div_result;
      out_rd   <= rd_q;
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed vectors, randomized ops against an arithmetic model,
// flush/reset/back-to-back timing scenarios. Cycle 0 is the cycle an op is presented.
// Inputs are driven 1 time unit after the rising edge, outputs sampled on the falling edge.
module tb_ex_muldiv;

  localparam int XLEN = 32;
  localparam int RW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_op;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic [RW-1:0]   in_rd;
  logic            out_valid;
  logic [XLEN-1:0] out_data;
  logic [RW-1:0]   out_rd;
  logic            busy;

  int n_cmp  = 0;
  int n_fail = 0;

  ex_muldiv #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_rd    (in_rd),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_rd   (out_rd),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: RISC-V M semantics computed with native 64-bit arithmetic
  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int ia, ib;
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    ia = a; ib = b; sa = ia; sb = ib; ua = a; ub = b;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        return ia / ib;
      end
      3'd5: begin
        if (b == 0) return 32'hFFFFFFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return ia % ib;
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return 2;
    if (b == 0) return 2;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 2;
    return XLEN + 1;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return $urandom_range(1, 20);
      4: return 32'h0 - $urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction

  // Present one op in cycle 0 and wait (bounded) for its out_valid pulse
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output int lat, output logic [31:0] data,
                       output logic [4:0] rdo, output logic b0, output logic b1);
    tick();
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_rd = rd;
    @(negedge clk);
    b0 = busy;
    lat = -1; data = 'x; rdo = 'x; b1 = 1'bx;
    for (int c = 1; c <= 60; c++) begin
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      if (c == 1) b1 = busy;
      if (out_valid) begin
        lat = c; data = out_data; rdo = out_rd;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_rd = '0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset out_data: got %h want 0", out_data); end
    n_cmp++; if (out_rd !== 5'h0) begin n_fail++; $display("FAIL reset out_rd: got %h want 0", out_rd); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", busy); end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic test_directed();
    vec_t v[$];
    int lat; logic [31:0] data; logic [4:0] rdo; logic b0, b1;
    v.push_back('{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 2});
    v.push_back('{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2});
    v.push_back('{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 2});
    v.push_back('{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 2});
    v.push_back('{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33});
    v.push_back('{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33});
    v.push_back('{3'd5, 32'd100,      32'd7,        32'd14,       33});
    v.push_back('{3'd7, 32'd100,      32'd7,        32'd2,        33});
    v.push_back('{3'd4, 32'h12345678, 32'h0,        32'hFFFFFFFF, 2});
    v.push_back('{3'd6, 32'h12345678, 32'h0,        32'h12345678, 2});
    v.push_back('{3'd5, 32'h12345678, 32'h0,        32'hFFFFFFFF, 2});
    v.push_back('{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2});
    v.push_back('{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 2});
    foreach (v[i]) begin
      do_op(v[i].op, v[i].a, v[i].b, 5'(i + 1), lat, data, rdo, b0, b1);
      n_cmp++; if (data !== v[i].exp) begin n_fail++; $display("FAIL directed[%0d] data: got %h want %h", i, data, v[i].exp); end
      n_cmp++; if (lat !== v[i].lat) begin n_fail++; $display("FAIL directed[%0d] latency: got %0d want %0d", i, lat, v[i].lat); end
      n_cmp++; if (rdo !== 5'(i + 1)) begin n_fail++; $display("FAIL directed[%0d] rd: got %0d want %0d", i, rdo, i + 1); end
      n_cmp++; if (b0 !== 1'b1 || b1 !== 1'b1) begin n_fail++; $display("FAIL directed[%0d] busy c0/c1: got %b%b want 11", i, b0, b1); end
    end
  endtask

  task automatic test_random();
    int lat; logic [31:0] data; logic [4:0] rdo; logic b0, b1;
    logic [2:0] op; logic [31:0] a, b; logic [4:0] rd;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7)); a = pick_operand(); b = pick_operand(); rd = 5'($urandom);
      do_op(op, a, b, rd, lat, data, rdo, b0, b1);
      n_cmp++; if (data !== ref_md(op, a, b)) begin n_fail++; $display("FAIL random[%0d] op%0d %h,%h data: got %h want %h", i, op, a, b, data, ref_md(op, a, b)); end
      n_cmp++; if (lat !== ref_lat(op, a, b)) begin n_fail++; $display("FAIL random[%0d] op%0d latency: got %0d want %0d", i, op, lat, ref_lat(op, a, b)); end
      n_cmp++; if (rdo !== rd) begin n_fail++; $display("FAIL random[%0d] rd: got %0d want %0d", i, rdo, rd); end
    end
  endtask

  // DIV flushed in cycle 10; MUL accepted in cycle 11 must complete in cycle 13
  task automatic test_flush();
    logic [31:0] prev; int pulses; int pcyc; logic [31:0] pdata; logic [4:0] prd;
    prev = out_data; pulses = 0; pcyc = -1; pdata = 'x; prd = 'x;
    tick();
    in_valid = 1'b1; in_op = 3'd4; in_a = 32'd1000; in_b = 32'd3; in_rd = 5'd9;
    for (int c = 1; c <= 45; c++) begin
      tick();
      in_valid = 1'b0;
      flush = (c == 10);
      if (c == 11) begin
        in_valid = 1'b1; in_op = 3'd0; in_a = 32'd6; in_b = 32'd7; in_rd = 5'd4;
      end
      @(negedge clk);
      if (c == 11) begin
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush in_ready c11: got %b want 1", in_ready); end
        n_cmp++; if (out_data !== prev) begin n_fail++; $display("FAIL flush out_data held: got %h want %h", out_data, prev); end
      end
      if (out_valid) begin pulses++; pcyc = c; pdata = out_data; prd = out_rd; end
    end
    n_cmp++; if (pulses !== 1) begin n_fail++; $display("FAIL flush pulse count: got %0d want 1", pulses); end
    n_cmp++; if (pcyc !== 13) begin n_fail++; $display("FAIL flush mul cycle: got %0d want 13", pcyc); end
    n_cmp++; if (pdata !== 32'd42) begin n_fail++; $display("FAIL flush mul data: got %h want %h", pdata, 32'd42); end
    n_cmp++; if (prd !== 5'd4) begin n_fail++; $display("FAIL flush mul rd: got %0d want 4", prd); end
  endtask

  // DIV then MUL presented in the DONE cycle: pulses in cycles 33 and 35
  task automatic test_back_to_back();
    int cyc[4]; logic [31:0] dat[4]; logic [4:0] rds[4]; int n;
    n = 0;
    tick();
    in_valid = 1'b1; in_op = 3'd5; in_a = 32'd1000; in_b = 32'd7; in_rd = 5'd3;
    for (int c = 1; c <= 45; c++) begin
      tick();
      in_valid = (c == 33);
      if (c == 33) begin in_op = 3'd0; in_a = 32'd9; in_b = 32'd11; in_rd = 5'd5; end
      @(negedge clk);
      if (c == 33) begin
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b in_ready in DONE: got %b want 1", in_ready); end
      end
      if (out_valid && n < 4) begin cyc[n] = c; dat[n] = out_data; rds[n] = out_rd; n++; end
    end
    n_cmp++; if (n !== 2) begin n_fail++; $display("FAIL b2b pulse count: got %0d want 2", n); end
    if (n >= 2) begin
      n_cmp++; if (cyc[0] !== 33 || cyc[1] !== 35) begin n_fail++; $display("FAIL b2b cycles: got %0d,%0d want 33,35", cyc[0], cyc[1]); end
      n_cmp++; if (dat[0] !== 32'd142 || dat[1] !== 32'd99) begin n_fail++; $display("FAIL b2b data: got %h,%h want %h,%h", dat[0], dat[1], 32'd142, 32'd99); end
      n_cmp++; if (rds[0] !== 5'd3 || rds[1] !== 5'd5) begin n_fail++; $display("FAIL b2b rd: got %0d,%0d want 3,5", rds[0], rds[1]); end
    end
  endtask

  // Flush in the DONE cycle with a new op presented: pulse stands, new op dropped
  task automatic test_flush_done();
    int pulses;
    pulses = 0;
    tick();
    in_valid = 1'b1; in_op = 3'd0; in_a = 32'd3; in_b = 32'd5; in_rd = 5'd2;
    for (int c = 1; c <= 10; c++) begin
      tick();
      flush = (c == 2);
      in_valid = (c == 2);
      if (c == 2) begin in_op = 3'd0; in_a = 32'd2; in_b = 32'd2; in_rd = 5'd7; end
      @(negedge clk);
      if (c == 2) begin
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_done out_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_data !== 32'd15) begin n_fail++; $display("FAIL flush_done out_data: got %h want %h", out_data, 32'd15); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_done busy: got %b want 0", busy); end
      end
      if (out_valid) pulses++;
    end
    flush = 1'b0;
    n_cmp++; if (pulses !== 1) begin n_fail++; $display("FAIL flush_done pulse count: got %0d want 1", pulses); end
  endtask

  // Reset in cycle 5 of a DIV: reset values in cycle 6, no pulse afterwards
  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    tick();
    in_valid = 1'b1; in_op = 3'd4; in_a = 32'd5000; in_b = 32'd13; in_rd = 5'd11;
    for (int c = 1; c <= 40; c++) begin
      tick();
      in_valid = 1'b0;
      rst = (c == 5);
      @(negedge clk);
      if (c == 6) begin
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL rst_mid out_data: got %h want 0", out_data); end
        n_cmp++; if (out_rd !== 5'h0) begin n_fail++; $display("FAIL rst_mid out_rd: got %h want 0", out_rd); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid in_ready: got %b want 1", in_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid busy: got %b want 0", busy); end
      end
      if (out_valid) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_fail++; $display("FAIL rst_mid pulse count: got %0d want 0", pulses); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_back_to_back();
    test_flush_done();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
